rom_bist_sig_ctrl: RTL and testbench

ROM BIST initiator that drives the BIST port group of a single-port ROM DFX wrapper: it takes the ROM onto the BIST clock, reads every word in ascending address order, and compacts the returned data into a MISR signature. At the end of the run it compares that signature against an expected value and reports pass or fail. It sits in the DFX partition, one instance per ROM, clocked by the same BIST clock that feeds the wrapper's BIST clock input.

---
 rtl/rom_bist_sig_ctrl.sv | 137 +++++++++++++
 tb/tb_rom_bist_sig_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bist_sig_ctrl.sv
// ROM BIST initiator: sweeps every ROM word in ascending order, compacts the
// returned data into a MISR and compares it against a latched expected value.
module rom_bist_sig_ctrl #(
  parameter int                  ROM_ADDR   = 11,
  parameter int                  ROM_WORDS  = 2048,
  parameter int                  ROM_BITS   = 32,
  parameter int                  RD_LATENCY = 1,
  parameter int                  SETUP_CYC  = 4,
  parameter logic [ROM_BITS-1:0] MISR_POLY  = 32'h04C11DB7,
  parameter logic [ROM_BITS-1:0] MISR_SEED  = 32'hFFFFFFFF
) (
  input  logic                BIST_CLK_ROM_IN,
  input  logic                BIST_RST_ROM_B,
  input  logic                BIST_START,
  input  logic [ROM_BITS-1:0] BIST_EXP_SIG,
  output logic                BIST_ROM_ENABLE,
  output logic [ROM_ADDR-1:0] BIST_ADDR_ROM_IN,
  output logic                BIST_REN_ROM,
  input  logic [ROM_BITS-1:0] DATA_ROM_OUT,
  output logic                BIST_BUSY,
  output logic                BIST_DONE,
  output logic                BIST_PASS,
  output logic [ROM_BITS-1:0] BIST_SIG
);

  localparam int CW = $clog2(SETUP_CYC + RD_LATENCY + 1);
  localparam logic [CW-1:0]       SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0]       DRAIN_LAST = CW'(RD_LATENCY - 1);
  localparam logic [ROM_ADDR-1:0] ADDR_LAST  = ROM_ADDR'(ROM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_READ, S_DRAIN, S_CMP, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [ROM_ADDR-1:0] r_addr;
  logic [ROM_ADDR-1:0] w_addr_nxt;
  logic                r_en;
  logic                r_ren;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ROM_BITS-1:0] r_misr;
  logic [ROM_BITS-1:0] r_exp;
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY:0]   w_vld_sh;
  logic                w_start;
  logic                w_en_nxt;
  logic                w_ren_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_upd;
  logic [ROM_BITS-1:0] w_misr_nxt;

  always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_ROM_B) begin
    if (!BIST_RST_ROM_B) r_state <= S_IDLE;
    else                 r_state <= w_nxt;
  end

  // Terminal address is compared, never an overflow, so a full
  // 2^ROM_ADDR sweep ends exactly on the all-ones address.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (BIST_START) w_nxt = S_SETUP;
      S_DONE:  if (BIST_START) w_nxt = S_SETUP;
      S_SETUP: if (r_cnt == SETUP_LAST) w_nxt = S_READ;
      S_READ:  if (r_addr == ADDR_LAST) w_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == DRAIN_LAST) w_nxt = S_CMP;
      S_CMP:   w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start    = (r_state == S_IDLE || r_state == S_DONE) && BIST_START;
    w_en_nxt   = w_nxt == S_SETUP || w_nxt == S_READ || w_nxt == S_DRAIN;
    w_ren_nxt  = w_nxt == S_READ;
    w_busy_nxt = w_en_nxt || w_nxt == S_CMP;
    w_done_nxt = w_nxt == S_DONE;
    w_addr_nxt = '0;
    if (r_state == S_READ && w_nxt == S_READ)
      w_addr_nxt = r_addr + 1'b1;
    w_cnt_nxt = '0;
    if (w_nxt == r_state && (r_state == S_SETUP || r_state == S_DRAIN))
      w_cnt_nxt = r_cnt + 1'b1;
    w_vld_sh   = {r_vld, r_ren};
    w_upd      = r_vld[RD_LATENCY-1];
    w_misr_nxt = {r_misr[ROM_BITS-2:0], 1'b0}
               ^ (r_misr[ROM_BITS-1] ? MISR_POLY : '0)
               ^ DATA_ROM_OUT;
  end

  // The signature register reads 0 out of reset and is seeded on run accept.
  always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_ROM_B) begin
    if (!BIST_RST_ROM_B) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_en   <= 1'b0;
      r_ren  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_vld  <= '0;
      r_misr <= '0;
      r_exp  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_addr <= w_addr_nxt;
      r_en   <= w_en_nxt;
      r_ren  <= w_ren_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_vld  <= w_vld_sh[RD_LATENCY-1:0];
      if (w_start) begin
        r_exp  <= BIST_EXP_SIG;
        r_misr <= MISR_SEED;
        r_pass <= 1'b0;
      end else begin
        if (w_upd) r_misr <= w_misr_nxt;
        if (r_state == S_CMP) r_pass <= r_misr == r_exp;
      end
    end
  end

  assign BIST_ROM_ENABLE  = r_en;
  assign BIST_ADDR_ROM_IN = r_addr;
  assign BIST_REN_ROM     = r_ren;
  assign BIST_BUSY        = r_busy;
  assign BIST_DONE        = r_done;
  assign BIST_PASS        = r_pass;
  assign BIST_SIG         = r_misr;

endmodule

// File: tb/tb_rom_bist_sig_ctrl.sv
// Bench for rom_bist_sig_ctrl: three parameterisations sharing one ROM image,
// checked against a queue-based signature and timeline model.
module tb_rom_bist_sig_ctrl;

  localparam int SU = 4;
  localparam int WT [3] = '{4, 2048, 8};
  localparam int LT [3] = '{1, 1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st [3];
  logic [31:0] ex [3];
  logic [31:0] rom [2048];

  logic        en_a, ren_a, busy_a, done_a, pass_a;
  logic [1:0]  addr_a;
  logic [31:0] sig_a, dat_a;
  logic        en_b, ren_b, busy_b, done_b, pass_b;
  logic [10:0] addr_b;
  logic [31:0] sig_b, dat_b;
  logic        en_c, ren_c, busy_c, done_c, pass_c;
  logic [2:0]  addr_c;
  logic [31:0] sig_c, dat_c, c_s0, c_s1;

  int errs = 0;
  int checks = 0;
  int sel = 0;

  rom_bist_sig_ctrl #(.ROM_ADDR(2), .ROM_WORDS(4)) dut_a (
    .BIST_CLK_ROM_IN(clk), .BIST_RST_ROM_B(rst_n),
    .BIST_START(st[0]), .BIST_EXP_SIG(ex[0]),
    .BIST_ROM_ENABLE(en_a), .BIST_ADDR_ROM_IN(addr_a),
    .BIST_REN_ROM(ren_a), .DATA_ROM_OUT(dat_a),
    .BIST_BUSY(busy_a), .BIST_DONE(done_a),
    .BIST_PASS(pass_a), .BIST_SIG(sig_a));

  rom_bist_sig_ctrl dut_b (
    .BIST_CLK_ROM_IN(clk), .BIST_RST_ROM_B(rst_n),
    .BIST_START(st[1]), .BIST_EXP_SIG(ex[1]),
    .BIST_ROM_ENABLE(en_b), .BIST_ADDR_ROM_IN(addr_b),
    .BIST_REN_ROM(ren_b), .DATA_ROM_OUT(dat_b),
    .BIST_BUSY(busy_b), .BIST_DONE(done_b),
    .BIST_PASS(pass_b), .BIST_SIG(sig_b));

  rom_bist_sig_ctrl #(.ROM_ADDR(3), .ROM_WORDS(8), .RD_LATENCY(3)) dut_c (
    .BIST_CLK_ROM_IN(clk), .BIST_RST_ROM_B(rst_n),
    .BIST_START(st[2]), .BIST_EXP_SIG(ex[2]),
    .BIST_ROM_ENABLE(en_c), .BIST_ADDR_ROM_IN(addr_c),
    .BIST_REN_ROM(ren_c), .DATA_ROM_OUT(dat_c),
    .BIST_BUSY(busy_c), .BIST_DONE(done_c),
    .BIST_PASS(pass_c), .BIST_SIG(sig_c));

  always @(posedge clk) if (ren_a) dat_a <= rom[int'(addr_a)];
  always @(posedge clk) if (ren_b) dat_b <= rom[int'(addr_b)];
  always @(posedge clk) begin
    c_s0  <= rom[int'(addr_c)];
    c_s1  <= c_s0;
    dat_c <= c_s1;
  end

  logic        g_en, g_ren, g_busy, g_done, g_pass;
  logic [10:0] g_addr;
  logic [31:0] g_sig;
  always_comb begin
    g_en = 0; g_ren = 0; g_busy = 0; g_done = 0; g_pass = 0;
    g_addr = '0; g_sig = '0;
    case (sel)
      0: begin
        g_en = en_a; g_ren = ren_a; g_busy = busy_a; g_done = done_a;
        g_pass = pass_a; g_addr = {9'd0, addr_a}; g_sig = sig_a;
      end
      1: begin
        g_en = en_b; g_ren = ren_b; g_busy = busy_b; g_done = done_b;
        g_pass = pass_b; g_addr = addr_b; g_sig = sig_b;
      end
      default: begin
        g_en = en_c; g_ren = ren_c; g_busy = busy_c; g_done = done_c;
        g_pass = pass_c; g_addr = {8'd0, addr_c}; g_sig = sig_c;
      end
    endcase
  end

  function automatic logic [31:0] step(logic [31:0] m, logic [31:0] d);
    return {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ d;
  endfunction

  function automatic logic [31:0] ref_sig(int nw);
    logic [31:0] m;
    m = 32'hFFFFFFFF;
    for (int i = 0; i < nw; i++) m = step(m, rom[i]);
    return m;
  endfunction

  // Drives one run and checks the cycle-by-cycle timeline against the model.
  task automatic run(input int s, input logic [31:0] e, input bit hold,
                     input int pulse_at, output int dcyc,
                     output logic dpass, output logic [31:0] dsig,
                     output int terr, output int ren_n, output int first);
    logic [31:0] seq [$];
    logic [31:0] m;
    int w, l, k, ea;
    bit een, eren, ebusy;
    w = WT[s]; l = LT[s];
    m = 32'hFFFFFFFF;
    seq = {m};
    for (int i = 0; i < w; i++) begin
      m = step(m, rom[i]);
      seq.push_back(m);
    end
    sel = s;
    dcyc = -1; terr = 0; ren_n = 0; first = -1;
    dpass = 1'bx; dsig = 'x;
    ex[s] = e;
    st[s] = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= w + 40; n++) begin
      if (!hold) st[s] = (n == pulse_at);
      @(negedge clk);
      een   = n <= SU + w + l;
      eren  = n > SU && n <= SU + w;
      ebusy = n <= SU + w + l + 1;
      ea    = eren ? n - SU - 1 : 0;
      k     = n - SU - l - 1;
      if (k < 0) k = 0;
      if (k > w) k = w;
      if (g_en !== een || g_ren !== eren || g_addr !== 11'(ea) ||
          g_busy !== ebusy || g_sig !== seq[k] ||
          (ebusy && g_pass !== 1'b0)) begin
        terr++;
        if (first < 0) first = n;
      end
      if (g_ren) ren_n++;
      if (g_done) begin
        dcyc = n; dpass = g_pass; dsig = g_sig;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!hold) st[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      ex[i] = '0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({en_a, ren_a, addr_a, busy_a, done_a, pass_a, sig_a} !== '0) begin
      errs++;
      $display("FAIL reset_a: got %h required 0",
               {en_a, ren_a, addr_a, busy_a, done_a, pass_a, sig_a});
    end
    checks++;
    if ({en_b, ren_b, addr_b, busy_b, done_b, pass_b, sig_b} !== '0) begin
      errs++;
      $display("FAIL reset_b: got %h required 0",
               {en_b, ren_b, addr_b, busy_b, done_b, pass_b, sig_b});
    end
    checks++;
    if ({en_c, ren_c, addr_c, busy_c, done_c, pass_c, sig_c} !== '0) begin
      errs++;
      $display("FAIL reset_c: got %h required 0",
               {en_c, ren_c, addr_c, busy_c, done_c, pass_c, sig_c});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vector;
    int d, t, r, f;
    logic p;
    logic [31:0] sg;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    run(0, 32'hC7B0424D, 0, 0, d, p, sg, t, r, f);
    checks++;
    if (d !== 11) begin errs++; $display("FAIL kv_done_cyc: got %0d required 11", d); end
    checks++;
    if (p !== 1'b1) begin errs++; $display("FAIL kv_pass: got %b required 1", p); end
    checks++;
    if (sg !== 32'hC7B0424D) begin errs++; $display("FAIL kv_sig: got %h required C7B0424D", sg); end
    checks++;
    if (t !== 0) begin errs++; $display("FAIL kv_trace: %0d bad cycles, first %0d, required 0", t, f); end
    run(0, 32'hC7B0424C, 0, 0, d, p, sg, t, r, f);
    checks++;
    if (d !== 11) begin errs++; $display("FAIL kv2_done_cyc: got %0d required 11", d); end
    checks++;
    if (p !== 1'b0) begin errs++; $display("FAIL kv2_pass: got %b required 0", p); end
    checks++;
    if (sg !== 32'hC7B0424D) begin errs++; $display("FAIL kv2_sig: got %h required C7B0424D", sg); end
  endtask

  task automatic test_random_small;
    int d, t, r, f;
    logic p;
    bit bad;
    logic [31:0] sg, want, e;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 4; i++) rom[i] = $urandom;
      want = ref_sig(4);
      bad  = 1'($urandom_range(0, 1));
      e    = bad ? want ^ (32'h1 << $urandom_range(0, 31)) : want;
      run(0, e, 0, 0, d, p, sg, t, r, f);
      checks++;
      if (p !== !bad) begin errs++; $display("FAIL rnd_pass[%0d]: got %b required %b", it, p, !bad); end
      checks++;
      if (sg !== want) begin errs++; $display("FAIL rnd_sig[%0d]: got %h required %h", it, sg, want); end
      checks++;
      if (t !== 0 || d !== 11) begin
        errs++;
        $display("FAIL rnd_trace[%0d]: bad=%0d first=%0d done=%0d required 0/11", it, t, f, d);
      end
    end
  endtask

  task automatic test_default_addr;
    int d, t, r, f;
    logic p;
    logic [31:0] sg, want;
    for (int i = 0; i < 2048; i++) rom[i] = 32'(i);
    want = ref_sig(2048);
    run(1, want, 0, 0, d, p, sg, t, r, f);
    checks++;
    if (d !== 2055) begin errs++; $display("FAIL def_done_cyc: got %0d required 2055", d); end
    checks++;
    if (r !== 2048) begin errs++; $display("FAIL def_ren_count: got %0d required 2048", r); end
    checks++;
    if (t !== 0) begin errs++; $display("FAIL def_trace: %0d bad cycles, first %0d, required 0", t, f); end
    checks++;
    if (sg !== want) begin errs++; $display("FAIL def_sig: got %h required %h", sg, want); end
    checks++;
    if (p !== 1'b1) begin errs++; $display("FAIL def_pass: got %b required 1", p); end
  endtask

  task automatic test_latency3;
    int d, t, r, f;
    logic p;
    logic [31:0] sg, want;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    want = ref_sig(8);
    run(2, want, 0, 0, d, p, sg, t, r, f);
    checks++;
    if (d !== 17) begin errs++; $display("FAIL lat3_done_cyc: got %0d required 17", d); end
    checks++;
    if (t !== 0) begin errs++; $display("FAIL lat3_trace: %0d bad cycles, first %0d, required 0", t, f); end
    checks++;
    if (sg !== want) begin errs++; $display("FAIL lat3_sig: got %h required %h", sg, want); end
    checks++;
    if (p !== 1'b1) begin errs++; $display("FAIL lat3_pass: got %b required 1", p); end
  endtask

  task automatic test_start_ignored;
    int d, t, r, f;
    logic p;
    logic [31:0] sg, want;
    for (int i = 0; i < 4; i++) rom[i] = $urandom;
    want = ref_sig(4);
    run(0, want, 0, 6, d, p, sg, t, r, f);
    checks++;
    if (d !== 11) begin errs++; $display("FAIL ign_done_cyc: got %0d required 11", d); end
    checks++;
    if (sg !== want || p !== 1'b1) begin
      errs++;
      $display("FAIL ign_sig: got %h/%b required %h/1", sg, p, want);
    end
    checks++;
    if (t !== 0) begin errs++; $display("FAIL ign_trace: %0d bad cycles, first %0d, required 0", t, f); end
  endtask

  task automatic test_back_to_back;
    int d, t, r, f;
    logic p;
    logic [31:0] sg, want;
    for (int i = 0; i < 4; i++) rom[i] = $urandom;
    want = ref_sig(4);
    run(0, want, 1, 0, d, p, sg, t, r, f);
    checks++;
    if (d !== 11 || p !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first: done=%0d pass=%b required 11/1", d, p);
    end
    for (int i = 0; i < 4; i++) rom[i] = $urandom;
    want = ref_sig(4);
    run(0, want ^ 32'h8000_0000, 0, 0, d, p, sg, t, r, f);
    checks++;
    if (d !== 11) begin errs++; $display("FAIL b2b_done_cyc: got %0d required 11", d); end
    checks++;
    if (sg !== want || p !== 1'b0) begin
      errs++;
      $display("FAIL b2b_sig: got %h/%b required %h/0", sg, p, want);
    end
    checks++;
    if (t !== 0) begin errs++; $display("FAIL b2b_trace: %0d bad cycles, first %0d, required 0", t, f); end
  endtask

  task automatic test_reset_mid_read;
    int d, t, r, f;
    logic p;
    logic [31:0] sg, want;
    for (int i = 0; i < 2048; i++) rom[i] = $urandom;
    want = ref_sig(2048);
    ex[1] = want;
    st[1] = 1'b1;
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({en_b, ren_b, addr_b, busy_b, done_b, pass_b, sig_b} !== '0) begin
      errs++;
      $display("FAIL rst_mid_async: got %h required 0",
               {en_b, ren_b, addr_b, busy_b, done_b, pass_b, sig_b});
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({en_b, ren_b, busy_b, done_b} !== 4'b0) begin
      errs++;
      $display("FAIL rst_mid_idle: got %b required 0000", {en_b, ren_b, busy_b, done_b});
    end
    run(1, want, 0, 0, d, p, sg, t, r, f);
    checks++;
    if (d !== 2055) begin errs++; $display("FAIL rst_rerun_done: got %0d required 2055", d); end
    checks++;
    if (sg !== want || p !== 1'b1) begin
      errs++;
      $display("FAIL rst_rerun_sig: got %h/%b required %h/1", sg, p, want);
    end
    checks++;
    if (t !== 0) begin errs++; $display("FAIL rst_rerun_trace: %0d bad cycles, first %0d, required 0", t, f); end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_random_small();
    test_default_addr();
    test_latency3();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
